// File: rtl/layer_compositor_if.sv
// Drawer-to-compositor bundle: per-layer draw requests/colours in, composited pixel and frame flags out.
// master = drawer/VGA side, slave = compositor.
interface layer_compositor_if #(
  parameter int NUM_LAYERS = 4
);
  logic                    startOfFrame;
  logic [NUM_LAYERS-1:0]   layerDR;
  logic [8*NUM_LAYERS-1:0] layerRGB;
  logic [7:0]              bgRGB;
  logic [NUM_LAYERS-1:0]   blinkMask;
  logic [7:0]              outRGB;
  logic [NUM_LAYERS-1:0]   collisionVec;
  logic                    collisionValid;
  logic                    blinkPhase;

  modport master (
    output startOfFrame, layerDR, layerRGB, bgRGB, blinkMask,
    input  outRGB, collisionVec, collisionValid, blinkPhase
  );

  modport slave (
    input  startOfFrame, layerDR, layerRGB, bgRGB, blinkMask,
    output outRGB, collisionVec, collisionValid, blinkPhase
  );
endinterface

// File: rtl/layer_compositor.sv
// Priority-resolves NUM_LAYERS drawers into one pixel with per-frame overlap flags and layer blinking.
// Latency: 1 cycle inputs -> outRGB; no backpressure, evaluated every pixel clock.
module layer_compositor #(
  parameter int          NUM_LAYERS   = 4,
  parameter logic [7:0]  TRANSPARENT  = 8'hFF,
  parameter int          BLINK_FRAMES = 15
) (
  input  logic                clk,
  input  logic                resetN,
  layer_compositor_if.slave   io_bus
);
  localparam int             CW       = $clog2(BLINK_FRAMES) + 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(BLINK_FRAMES - 1);

  logic [NUM_LAYERS-1:0] w_active;
  logic [NUM_LAYERS-1:0] w_active_m1;
  logic [NUM_LAYERS-1:0] w_visible;
  logic [NUM_LAYERS-1:0] w_hit;
  logic                  w_multi;
  logic [7:0]            w_pix;

  logic [7:0]            r_outRGB;
  logic [NUM_LAYERS-1:0] r_acc;
  logic [NUM_LAYERS-1:0] r_collisionVec;
  logic                  r_collisionValid;
  logic                  r_blinkPhase;
  logic [CW-1:0]         r_cnt;

  always_comb begin
    w_active = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      w_active[i] = io_bus.layerDR[i] && (io_bus.layerRGB[8*i +: 8] != TRANSPARENT);
    end
  end

  // Blink only hides a layer from colour selection; overlap still sees it as active.
  assign w_visible   = w_active & ~(io_bus.blinkMask & {NUM_LAYERS{~r_blinkPhase}});
  // Clearing the lowest set bit leaves something only when two or more layers are active.
  assign w_active_m1 = w_active - NUM_LAYERS'(1);
  assign w_multi     = (w_active & w_active_m1) != '0;
  assign w_hit       = w_multi ? w_active : '0;

  always_comb begin
    w_pix = io_bus.bgRGB;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (w_visible[i]) w_pix = io_bus.layerRGB[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_outRGB <= 8'h00;
    end else begin
      r_outRGB <= w_pix;
    end
  end

  // The startOfFrame pixel's own hit still belongs to the frame being reported.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_acc            <= '0;
      r_collisionVec   <= '0;
      r_collisionValid <= 1'b0;
    end else if (io_bus.startOfFrame) begin
      r_acc            <= '0;
      r_collisionVec   <= r_acc | w_hit;
      r_collisionValid <= 1'b1;
    end else begin
      r_acc            <= r_acc | w_hit;
      r_collisionValid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_cnt        <= '0;
      r_blinkPhase <= 1'b1;
    end else if (io_bus.startOfFrame) begin
      if (r_cnt == CNT_LAST) begin
        r_cnt        <= '0;
        r_blinkPhase <= ~r_blinkPhase;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign io_bus.outRGB         = r_outRGB;
  assign io_bus.collisionVec   = r_collisionVec;
  assign io_bus.collisionValid = r_collisionValid;
  assign io_bus.blinkPhase     = r_blinkPhase;
endmodule

// File: tb/tb_layer_compositor.sv
// Directed bench for layer_compositor: priority, transparency, collision frames, reset and blink.
module tb_layer_compositor;
  logic clk = 1'b0;
  logic resetN;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  layer_compositor_if #(.NUM_LAYERS(4)) bus ();

  layer_compositor #(
    .NUM_LAYERS  (4),
    .TRANSPARENT (8'hFF),
    .BLINK_FRAMES(2)
  ) dut (
    .clk   (clk),
    .resetN(resetN),
    .io_bus(bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rgb(input logic [7:0] r0, input logic [7:0] r1,
                         input logic [7:0] r2, input logic [7:0] r3);
    bus.layerRGB = {r3, r2, r1, r0};
  endtask

  task automatic sof_pulse();
    bus.startOfFrame = 1'b1;
    tick();
    bus.startOfFrame = 1'b0;
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    bus.startOfFrame = 1'b0;
    bus.bgRGB = 8'h25;
    bus.blinkMask = 4'b0000;
    bus.layerDR = 4'b0110;
    set_rgb(8'h00, 8'h1C, 8'hE0, 8'h00);
    tick();
    tick();
    n_cmp++; if (bus.outRGB !== 8'h00) begin n_bad++; $display("FAIL reset_out: got %h want 00", bus.outRGB); end
    n_cmp++; if (bus.collisionVec !== 4'b0000) begin n_bad++; $display("FAIL reset_vec: got %b want 0000", bus.collisionVec); end
    n_cmp++; if (bus.collisionValid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", bus.collisionValid); end
    n_cmp++; if (bus.blinkPhase !== 1'b1) begin n_bad++; $display("FAIL reset_phase: got %b want 1", bus.blinkPhase); end
    resetN = 1'b1;
  endtask

  task automatic test_priority();
    bus.layerDR = 4'b0110;
    set_rgb(8'h00, 8'h1C, 8'hE0, 8'h00);
    tick();
    n_cmp++; if (bus.outRGB !== 8'h1C) begin n_bad++; $display("FAIL prio_l1: got %h want 1c", bus.outRGB); end
    bus.layerDR = 4'b0000;
    tick();
    n_cmp++; if (bus.outRGB !== 8'h25) begin n_bad++; $display("FAIL prio_bg: got %h want 25", bus.outRGB); end
    bus.layerDR = 4'b1001;
    set_rgb(8'h40, 8'h00, 8'h00, 8'h03);
    tick();
    n_cmp++; if (bus.outRGB !== 8'h40) begin n_bad++; $display("FAIL prio_l0: got %h want 40", bus.outRGB); end
    bus.layerDR = 4'b0000;
    tick();
  endtask

  task automatic test_transparent();
    sof_pulse();
    n_cmp++; if (bus.collisionVec !== 4'b1111) begin n_bad++; $display("FAIL prio_frame_vec: got %b want 1111", bus.collisionVec); end
    n_cmp++; if (bus.collisionValid !== 1'b1) begin n_bad++; $display("FAIL prio_frame_valid: got %b want 1", bus.collisionValid); end
    bus.layerDR = 4'b1001;
    set_rgb(8'hFF, 8'h00, 8'h00, 8'h03);
    tick();
    n_cmp++; if (bus.outRGB !== 8'h03) begin n_bad++; $display("FAIL transp_out: got %h want 03", bus.outRGB); end
    tick();
    bus.layerDR = 4'b0000;
    sof_pulse();
    n_cmp++; if (bus.collisionVec !== 4'b0000) begin n_bad++; $display("FAIL transp_vec: got %b want 0000", bus.collisionVec); end
  endtask

  task automatic test_collision();
    bus.layerDR = 4'b0000;
    sof_pulse();
    bus.layerDR = 4'b1010;
    set_rgb(8'hFF, 8'h11, 8'h00, 8'h33);
    repeat (5) tick();
    n_cmp++; if (bus.outRGB !== 8'h11) begin n_bad++; $display("FAIL coll_out: got %h want 11", bus.outRGB); end
    bus.layerDR = 4'b0000;
    tick();
    sof_pulse();
    n_cmp++; if (bus.collisionVec !== 4'b1010) begin n_bad++; $display("FAIL coll_vec: got %b want 1010", bus.collisionVec); end
    n_cmp++; if (bus.collisionValid !== 1'b1) begin n_bad++; $display("FAIL coll_valid_hi: got %b want 1", bus.collisionValid); end
    tick();
    n_cmp++; if (bus.collisionValid !== 1'b0) begin n_bad++; $display("FAIL coll_valid_lo: got %b want 0", bus.collisionValid); end
    n_cmp++; if (bus.collisionVec !== 4'b1010) begin n_bad++; $display("FAIL coll_vec_hold: got %b want 1010", bus.collisionVec); end
    repeat (3) tick();
    sof_pulse();
    n_cmp++; if (bus.collisionVec !== 4'b0000) begin n_bad++; $display("FAIL coll_clean_frame: got %b want 0000", bus.collisionVec); end
  endtask

  task automatic test_back_to_back();
    bus.startOfFrame = 1'b1;
    bus.layerDR = 4'b0011;
    set_rgb(8'h0A, 8'h0B, 8'h00, 8'h00);
    tick();
    n_cmp++; if (bus.collisionVec !== 4'b0011) begin n_bad++; $display("FAIL b2b_same_cycle_vec: got %b want 0011", bus.collisionVec); end
    n_cmp++; if (bus.collisionValid !== 1'b1) begin n_bad++; $display("FAIL b2b_valid1: got %b want 1", bus.collisionValid); end
    bus.layerDR = 4'b0000;
    tick();
    n_cmp++; if (bus.collisionVec !== 4'b0000) begin n_bad++; $display("FAIL b2b_empty_vec: got %b want 0000", bus.collisionVec); end
    n_cmp++; if (bus.collisionValid !== 1'b1) begin n_bad++; $display("FAIL b2b_valid2: got %b want 1", bus.collisionValid); end
    bus.startOfFrame = 1'b0;
    tick();
    n_cmp++; if (bus.collisionValid !== 1'b0) begin n_bad++; $display("FAIL b2b_valid_end: got %b want 0", bus.collisionValid); end
  endtask

  task automatic test_reset_midframe();
    sof_pulse();
    bus.layerDR = 4'b1010;
    set_rgb(8'h00, 8'h11, 8'h00, 8'h33);
    repeat (3) tick();
    resetN = 1'b0;
    #1;
    n_cmp++; if (bus.outRGB !== 8'h00) begin n_bad++; $display("FAIL midrst_out: got %h want 00", bus.outRGB); end
    tick();
    tick();
    resetN = 1'b1;
    bus.layerDR = 4'b0000;
    tick();
    sof_pulse();
    n_cmp++; if (bus.collisionVec !== 4'b0000) begin n_bad++; $display("FAIL midrst_vec: got %b want 0000", bus.collisionVec); end
    n_cmp++; if (bus.collisionValid !== 1'b1) begin n_bad++; $display("FAIL midrst_valid: got %b want 1", bus.collisionValid); end
  endtask

  task automatic test_blink();
    resetN = 1'b0;
    bus.blinkMask = 4'b0001;
    bus.layerDR = 4'b0011;
    set_rgb(8'h50, 8'h60, 8'h00, 8'h00);
    tick();
    resetN = 1'b1;
    n_cmp++; if (bus.blinkPhase !== 1'b1) begin n_bad++; $display("FAIL blink_phase_rst: got %b want 1", bus.blinkPhase); end
    tick();
    n_cmp++; if (bus.outRGB !== 8'h50) begin n_bad++; $display("FAIL blink_on_out: got %h want 50", bus.outRGB); end
    sof_pulse();
    n_cmp++; if (bus.blinkPhase !== 1'b1) begin n_bad++; $display("FAIL blink_phase_sof1: got %b want 1", bus.blinkPhase); end
    tick();
    n_cmp++; if (bus.outRGB !== 8'h50) begin n_bad++; $display("FAIL blink_on_out2: got %h want 50", bus.outRGB); end
    sof_pulse();
    n_cmp++; if (bus.blinkPhase !== 1'b0) begin n_bad++; $display("FAIL blink_phase_sof2: got %b want 0", bus.blinkPhase); end
    n_cmp++; if (bus.outRGB !== 8'h50) begin n_bad++; $display("FAIL blink_edge_pixel: got %h want 50", bus.outRGB); end
    tick();
    n_cmp++; if (bus.outRGB !== 8'h60) begin n_bad++; $display("FAIL blink_hidden_next: got %h want 60", bus.outRGB); end
    bus.layerDR = 4'b0001;
    tick();
    n_cmp++; if (bus.outRGB !== 8'h25) begin n_bad++; $display("FAIL blink_hidden_bg: got %h want 25", bus.outRGB); end
    bus.layerDR = 4'b0011;
    tick();
    sof_pulse();
    n_cmp++; if (bus.collisionVec !== 4'b0011) begin n_bad++; $display("FAIL blink_hidden_coll: got %b want 0011", bus.collisionVec); end
    n_cmp++; if (bus.blinkPhase !== 1'b0) begin n_bad++; $display("FAIL blink_phase_sof3: got %b want 0", bus.blinkPhase); end
    tick();
    n_cmp++; if (bus.outRGB !== 8'h60) begin n_bad++; $display("FAIL blink_hidden_out3: got %h want 60", bus.outRGB); end
    sof_pulse();
    n_cmp++; if (bus.blinkPhase !== 1'b1) begin n_bad++; $display("FAIL blink_phase_sof4: got %b want 1", bus.blinkPhase); end
    tick();
    n_cmp++; if (bus.outRGB !== 8'h50) begin n_bad++; $display("FAIL blink_visible_again: got %h want 50", bus.outRGB); end
  endtask

  initial begin
    test_reset();
    test_priority();
    test_transparent();
    test_collision();
    test_back_to_back();
    test_reset_midframe();
    test_blink();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
